// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

    // Sequential next PC; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of imem request/response, redirect and decode-side signals of the fetch stage.
// Latency: n/a (wires only). Optional stats outputs exist when FETCH_STATS_EN is defined.
// Backpressure: ImemReqReady stalls requests, StallD stalls decode; responses cannot be stalled.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic            ImemReqValid;
    logic [XLEN-1:0] ImemReqAddr;
    logic            ImemReqReady;
    logic            ImemRespValid;
    logic [ILEN-1:0] ImemRespData;
    logic            RedirectValid;
    logic [XLEN-1:0] RedirectPC;
    logic            StallD;
    logic            InstrValidD;
    logic [ILEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
`ifdef FETCH_STATS_EN
    logic [31:0]     StatIssued;
    logic [31:0]     StatDropped;

    modport master (
        output ImemReqValid, ImemReqAddr, InstrValidD, InstrD, PCD, PCPlus4D,
        output StatIssued, StatDropped,
        input  ImemReqReady, ImemRespValid, ImemRespData, RedirectValid, RedirectPC, StallD
    );
    modport slave (
        input  ImemReqValid, ImemReqAddr, InstrValidD, InstrD, PCD, PCPlus4D,
        input  StatIssued, StatDropped,
        output ImemReqReady, ImemRespValid, ImemRespData, RedirectValid, RedirectPC, StallD
    );
`else
    modport master (
        output ImemReqValid, ImemReqAddr, InstrValidD, InstrD, PCD, PCPlus4D,
        input  ImemReqReady, ImemRespValid, ImemRespData, RedirectValid, RedirectPC, StallD
    );
    modport slave (
        input  ImemReqValid, ImemReqAddr, InstrValidD, InstrD, PCD, PCPlus4D,
        output ImemReqReady, ImemRespValid, ImemRespData, RedirectValid, RedirectPC, StallD
    );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns FetchPC, issues in-order imem requests, queues returned words for decode (FETCH_STATS_EN adds counters).
// Latency: request accepted in cycle N, response in N+k -> InstrValidD in N+k+1; 1 instr/cycle when k <= DEPTH-1.
// Backpressure: requests stop when DEPTH entries are allocated; StallD holds the head; redirects flush and drop in-flight data.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    // Redirects can stack pending drops beyond DEPTH, so this is wider than the pointers.
    localparam int DCW = 16;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    fetch_entry_t    q [DEPTH];
    logic [PW-1:0]   head_ptr, fill_ptr, alloc_ptr;
    logic [XLEN-1:0] fetch_pc;
    logic [DCW-1:0]  drop_cnt;

    logic [PW-1:0]   used, inflight;
    logic            issue, accept, resp_keep, resp_drop, pop;
    logic [DCW-1:0]  drop_next;
    fetch_entry_t    head_e;

    // Queue occupancy, handshakes and the drop count a redirect would leave behind.
    always_comb begin
        used      = alloc_ptr - head_ptr;
        inflight  = alloc_ptr - fill_ptr;
        issue     = !reset && (used != FULL) && !bus.RedirectValid;
        accept    = issue && bus.ImemReqReady;
        resp_drop = bus.ImemRespValid && (drop_cnt != '0);
        resp_keep = bus.ImemRespValid && (drop_cnt == '0) && !bus.RedirectValid;
        head_e    = q[head_ptr[AW-1:0]];
        pop       = head_e.filled && !bus.StallD;
        // A response arriving with the redirect is one of the in-flight ones and is discarded now.
        drop_next = drop_cnt + DCW'(inflight) - DCW'(bus.ImemRespValid);
    end

    assign bus.ImemReqValid = issue;
    assign bus.ImemReqAddr  = fetch_pc;
    assign bus.InstrValidD  = head_e.filled;
    assign bus.InstrD       = head_e.filled ? head_e.instr : '0;
    assign bus.PCD          = head_e.filled ? head_e.pc : '0;
    assign bus.PCPlus4D     = head_e.filled ? pc_plus4(head_e.pc) : '0;

    // Queue storage, pointers, FetchPC and drop counter; redirect overrides issue/fill/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_ptr <= '0;
            fetch_pc  <= RESET_PC;
            drop_cnt  <= '0;
        end else if (bus.RedirectValid) begin
            for (int i = 0; i < DEPTH; i++) q[i].filled <= 1'b0;
            head_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_ptr <= '0;
            fetch_pc  <= bus.RedirectPC & ~XLEN'(3);
            drop_cnt  <= drop_next;
        end else begin
            if (accept) begin
                q[alloc_ptr[AW-1:0]].pc     <= fetch_pc;
                q[alloc_ptr[AW-1:0]].filled <= 1'b0;
                alloc_ptr <= alloc_ptr + 1'b1;
                fetch_pc  <= pc_plus4(fetch_pc);
            end
            if (resp_keep) begin
                q[fill_ptr[AW-1:0]].instr  <= bus.ImemRespData;
                q[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (pop) begin
                q[head_ptr[AW-1:0]].filled <= 1'b0;
                head_ptr <= head_ptr + 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_issued, stat_dropped;

    // Saturating activity counters; only reset clears them, redirects do not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
        end else begin
            if (accept && (stat_issued != '1)) stat_issued <= stat_issued + 1'b1;
            if (bus.ImemRespValid && !resp_keep && (stat_dropped != '1)) stat_dropped <= stat_dropped + 1'b1;
        end
    end

    assign bus.StatIssued  = stat_issued;
    assign bus.StatDropped = stat_dropped;
`endif

    // A response with nothing outstanding and nothing to drop means imem and fetch disagree.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(bus.ImemRespValid && (fill_ptr == alloc_ptr) && (drop_cnt == '0)));

endmodule
